// File: rtl/wb_data_ram_slave.sv
// ============================================================================
// Module   : wb_data_ram_slave
// Purpose  : Wishbone B3 classic data RAM responder with byte lanes, registered
//            reads and programmable wait states. Optional macro WB_ERR_EN turns
//            out-of-range addresses into error responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_data_ram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int         c_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] c_WAIT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_word;
  logic [3:0]              r_sel;
  logic [31:0]             r_dat;
  logic                    r_oob;
  logic                    r_ack;
  logic                    r_err;
  logic [31:0]             r_dat_o;
  logic [31:0]             r_mem [c_DEPTH];

  logic                    w_req;
  logic                    w_oob_in;
  logic                    w_from_idle;
  logic                    w_from_wait;
  logic                    w_enter;
  logic                    w_we;
  logic [ADDR_WIDTH-1:0]   w_word;
  logic [3:0]              w_sel;
  logic [31:0]             w_dat;
  logic                    w_oob;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_unused;

  assign w_req = wb_cyc_i & wb_stb_i;

`ifdef WB_ERR_EN
  assign w_oob_in = |wb_adr_i[31:ADDR_WIDTH+2];
  assign w_unused = ^wb_adr_i[1:0];
`else
  assign w_oob_in = 1'b0;
  assign w_unused = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};
`endif

  // With zero wait states the RESP-entry edge is the sampling edge itself,
  // so the live bus inputs are used instead of the latched copies.
  assign w_from_idle = (r_state == S_IDLE) && w_req && (c_WAIT == 4'd0);
  assign w_from_wait = (r_state == S_WAIT) && w_req && (r_cnt == 4'd1);
  assign w_enter     = w_from_idle | w_from_wait;

  assign w_we   = w_from_idle ? wb_we_i : r_we;
  assign w_word = w_from_idle ? wb_adr_i[ADDR_WIDTH+1:2] : r_word;
  assign w_sel  = w_from_idle ? wb_sel_i : r_sel;
  assign w_dat  = w_from_idle ? wb_dat_i : r_dat;
  assign w_oob  = w_from_idle ? w_oob_in : r_oob;

  assign w_wr = w_enter & w_we & ~w_oob;
  assign w_rd = w_enter & ~w_we & ~w_oob;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_word  <= '0;
      r_sel   <= 4'd0;
      r_dat   <= 32'h0;
      r_oob   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= 32'h0;
    end else begin
      r_ack <= w_enter & ~w_oob;
      r_err <= w_enter & w_oob;
      if (w_rd) begin
        r_dat_o <= r_mem[w_word];
      end
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we    <= wb_we_i;
            r_word  <= wb_adr_i[ADDR_WIDTH+1:2];
            r_sel   <= wb_sel_i;
            r_dat   <= wb_dat_i;
            r_oob   <= w_oob_in;
            r_cnt   <= c_WAIT;
            r_state <= (c_WAIT == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM array carries no reset; a reset held at an edge suppresses the write.
  always_ff @(posedge clk) begin
    if (w_wr && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (w_sel[b]) begin
          r_mem[w_word][8*b +: 8] <= w_dat[8*b +: 8];
        end
      end
    end
  end

  assign wb_dat_o = r_dat_o;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_data_ram_slave.sv
// ============================================================================
// Module   : tb_wb_data_ram_slave
// Purpose  : Self-checking bench for wb_data_ram_slave at 0, 1 and 3 wait states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_data_ram_slave;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc  [3];
  logic        stb  [3];
  logic        we   [3];
  logic [31:0] adr  [3];
  logic [3:0]  sel  [3];
  logic [31:0] dati [3];
  logic [31:0] dato [3];
  logic        ack  [3];
  logic        err  [3];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mm   [3][DEPTH];
  logic [31:0] last [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_data_ram_slave #(
      .ADDR_WIDTH (10),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .wb_cyc_i(cyc[g]),
      .wb_stb_i(stb[g]),
      .wb_we_i (we[g]),
      .wb_adr_i(adr[g]),
      .wb_sel_i(sel[g]),
      .wb_dat_i(dati[g]),
      .wb_dat_o(dato[g]),
      .wb_ack_o(ack[g]),
      .wb_err_o(err[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h", nm, act, exp);
    end
  endtask

  task automatic xfer_check(input int k, input bit w, input logic [31:0] a,
                            input logic [3:0] s, input logic [31:0] d,
                            input logic [31:0] exp_rd, input bit exp_err,
                            input string nm);
    int          lat = 0;
    logic [31:0] rd  = 32'h0;
    logic        e   = 1'b0;
    logic        a_seen = 1'b0;
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dati[k] = d;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (ack[k] || err[k]) begin
        lat = c; rd = dato[k]; e = err[k]; a_seen = ack[k];
      end
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
    chk({nm, "_latency"}, 32'(lat), 32'(ws_of(k) + 1));
    chk({nm, "_dat"}, rd, exp_rd);
    chk({nm, "_err"}, {31'h0, e}, {31'h0, exp_err});
    chk({nm, "_ack"}, {31'h0, a_seen}, {31'h0, ~exp_err});
    @(posedge clk); #1;
    chk({nm, "_pulse_width"}, {31'h0, ack[k] | err[k]}, 32'h0);
    last[k] = exp_rd;
  endtask

  typedef struct {
    int          k;
    bit          w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    bit          w;
    logic [31:0] d, exp_rd;
    logic [3:0]  s;
    int          wi, acks, prev;

    for (int k = 0; k < 3; k++) begin
      cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = 0; sel[k] = 0; dati[k] = 0;
      last[k] = 32'h0;
    end

    tbl[0]  = '{1, 1, 32'h040, 4'hF, 32'hDEADBEEF, 32'h00000000};
    tbl[1]  = '{1, 0, 32'h040, 4'hF, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1, 1, 32'h040, 4'h4, 32'h00AA0000, 32'hDEADBEEF};
    tbl[3]  = '{1, 0, 32'h040, 4'h0, 32'h0,        32'hDEAABEEF};
    tbl[4]  = '{1, 1, 32'h040, 4'h0, 32'h11111111, 32'hDEAABEEF};
    tbl[5]  = '{1, 0, 32'h040, 4'hF, 32'h0,        32'hDEAABEEF};
    tbl[6]  = '{1, 1, 32'hFFC, 4'hF, 32'hCAFEF00D, 32'hDEAABEEF};
    tbl[7]  = '{1, 0, 32'hFFC, 4'hF, 32'h0,        32'hCAFEF00D};
    tbl[8]  = '{1, 1, 32'h000, 4'hF, 32'h5A5A5A5A, 32'hCAFEF00D};
    tbl[9]  = '{1, 0, 32'h043, 4'hF, 32'h0,        32'hDEAABEEF};
    tbl[10] = '{0, 1, 32'h040, 4'hF, 32'h01234567, 32'h00000000};
    tbl[11] = '{0, 0, 32'h040, 4'hF, 32'h0,        32'h01234567};
    tbl[12] = '{0, 1, 32'h040, 4'h8, 32'hAB000000, 32'h01234567};
    tbl[13] = '{0, 0, 32'h040, 4'hF, 32'h0,        32'hAB234567};
    tbl[14] = '{2, 1, 32'h040, 4'hF, 32'hDEAABEEF, 32'h00000000};
    tbl[15] = '{2, 0, 32'h040, 4'hF, 32'h0,        32'hDEAABEEF};

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_dat", dato[k], 32'h0);
      chk("reset_ack", {31'h0, ack[k]}, 32'h0);
      chk("reset_err", {31'h0, err[k]}, 32'h0);
    end

    for (int i = 0; i < 16; i++) begin
      xfer_check(tbl[i].k, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d,
                 tbl[i].exp_rd, 1'b0, $sformatf("vec%0d", i));
    end

    // Abort: stb dropped after the sampling edge on the 3-wait-state instance
    @(negedge clk);
    cyc[2] = 1; stb[2] = 1; we[2] = 1; adr[2] = 32'h40; sel[2] = 4'hF; dati[2] = 32'h12345678;
    @(posedge clk); #1;
    @(negedge clk); stb[2] = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("abort_no_ack", {31'h0, ack[2] | err[2]}, 32'h0);
    end
    cyc[2] = 0;
    xfer_check(2, 0, 32'h40, 4'hF, 32'h0, 32'hDEAABEEF, 1'b0, "abort_readback");

    // Reset while a read sits in WAIT
    @(negedge clk);
    cyc[2] = 1; stb[2] = 1; we[2] = 0; adr[2] = 32'h40;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_ack", {31'h0, ack[2]}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("rst_mid_dat", dato[k], 32'h0);
      last[k] = 32'h0;
    end
    @(negedge clk); cyc[2] = 0; stb[2] = 0;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("rst_after_no_ack", {31'h0, ack[2]}, 32'h0);
    end
    xfer_check(2, 0, 32'h40, 4'hF, 32'h0, 32'hDEAABEEF, 1'b0, "rst_after_read");

    // Back-to-back reads with strobe held, zero wait states
    @(negedge clk);
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 32'h40;
    acks = 0; prev = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      chk("b2b_ack_pattern", {31'h0, ack[0]}, {31'h0, 1'(c % 2)});
      if (ack[0]) begin
        acks++;
        chk("b2b_dat", dato[0], 32'hAB234567);
      end
      chk("b2b_not_consecutive", 32'(prev & int'(ack[0])), 32'h0);
      prev = int'(ack[0]);
    end
    cyc[0] = 0; stb[0] = 0;
    chk("b2b_ack_count", 32'(acks), 32'd3);
    last[0] = 32'hAB234567;
    @(posedge clk); #1;

    // Out-of-range address one word past the top
`ifdef WB_ERR_EN
    xfer_check(1, 1, 32'(4 * DEPTH), 4'hF, 32'hFFFFFFFF, last[1], 1'b1, "oob_write");
    xfer_check(1, 0, 32'h0, 4'hF, 32'h0, 32'h5A5A5A5A, 1'b0, "oob_word0");
`else
    xfer_check(1, 1, 32'(4 * DEPTH), 4'hF, 32'hFFFFFFFF, last[1], 1'b0, "oob_write");
    xfer_check(1, 0, 32'h0, 4'hF, 32'h0, 32'hFFFFFFFF, 1'b0, "oob_word0");
`endif

    // Randomized traffic against a word-array model over words 64..79
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        d = $urandom;
        mm[k][64 + i] = d;
        xfer_check(k, 1, 32'(4 * (64 + i)), 4'hF, d, last[k], 1'b0, "rnd_init");
      end
      for (int i = 0; i < 30; i++) begin
        w  = 1'($urandom_range(0, 1));
        wi = 64 + int'($urandom_range(0, 15));
        s  = 4'($urandom_range(0, 15));
        d  = $urandom;
        if (w) begin
          exp_rd = last[k];
          for (int b = 0; b < 4; b++)
            if (s[b]) mm[k][wi][8*b +: 8] = d[8*b +: 8];
        end else begin
          exp_rd = mm[k][wi];
        end
        xfer_check(k, w, 32'(4 * wi) | 32'($urandom_range(0, 3)), s, d, exp_rd, 1'b0,
                   $sformatf("rnd_k%0d_%0d", k, i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
